// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor -> 8-bit quotient + 4-bit remainder.
// Latency: DIVIDEND_W+1 clocks from operand presentation to out_valid (1 clock when divisor is zero).
// Backpressure: in_ready only while idle; a finished result is held in DONE until out_ready.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_valid/in_ready             operand handshake (dividend, divisor)
//   out_valid/out_ready           result handshake (quotient, remainder, div_by_zero)
//   div_by_zero                   result belongs to a divisor==0 request (quotient all ones, remainder 0)
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DIVIDEND_W-1:0]   n_q, n_d;
  logic [DIVISOR_W-1:0]    d_q, d_d;
  logic [DIVISOR_W-1:0]    r_q, r_d;
  logic [DIVIDEND_W-1:0]   q_q, q_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dbz_q, dbz_d;

  logic                    accept;
  logic                    fire_out;
  logic [DIVISOR_W:0]      trial;
  logic                    trial_ge;
  logic [DIVISOR_W-1:0]    trial_diff;

  assign accept   = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  // Shift the next dividend bit into the partial remainder. The running
  // remainder is always < d, so trial < 2*d and the difference fits
  // DIVISOR_W bits; the carry-out of the narrow subtraction can be dropped.
  assign trial      = {r_q, n_q[cnt_q]};
  assign trial_ge   = (trial >= {1'b0, d_q});
  assign trial_diff = trial[DIVISOR_W-1:0] - d_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (fire_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

  // Datapath next-state
  always_comb begin
    n_d   = n_q;
    d_d   = d_q;
    r_d   = r_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          n_d   = dividend;
          d_d   = divisor;
          cnt_d = CNT_W'(DIVIDEND_W - 1);
          r_d   = '0;
          if (divisor == '0) begin
            q_d   = '1;
            dbz_d = 1'b1;
          end else begin
            q_d   = '0;
            dbz_d = 1'b0;
          end
        end
      end
      CALC: begin
        r_d        = trial_ge ? trial_diff : trial[DIVISOR_W-1:0];
        q_d[cnt_q] = trial_ge;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q   <= '0;
      d_q   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      d_q   <= d_d;
      r_q   <= r_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: reset, fixed vectors, divide-by-zero,
// result backpressure, reset abort, back-to-back and an exhaustive sweep with random stalls.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int passes = 0;

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Shift-and-add model of the 4-bit-multiplier datapath that the divider undoes.
  function automatic int mult_model(input int a, input int b);
    int acc;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc + (a << i);
    end
    return acc;
  endfunction

  // Presents one request from IDLE, waits (bounded) for the result, holds it
  // for 'stall' cycles and then completes the output handshake.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d, input int stall,
                        output int lat, output logic [7:0] q, output logic [3:0] r,
                        output logic z);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    repeat (stall) tick;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) tick;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (quotient !== 8'd0) $display("FAIL reset_quotient got=%0d exp=0", quotient); else passes++;
    checks++; if (remainder !== 4'd0) $display("FAIL reset_remainder got=%0d exp=0", remainder); else passes++;
    checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got=%b exp=0", div_by_zero); else passes++;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    run_op(8'd200, 4'd7, 0, lat, q, r, z);
    checks++; if (lat !== 9) $display("FAIL basic_latency got=%0d exp=9", lat); else passes++;
    checks++; if (q !== 8'd28) $display("FAIL basic_quotient got=%0d exp=28", q); else passes++;
    checks++; if (r !== 4'd4) $display("FAIL basic_remainder got=%0d exp=4", r); else passes++;
    checks++; if (z !== 1'b0) $display("FAIL basic_dbz got=%b exp=0", z); else passes++;
  endtask

  task automatic test_corners;
    logic [7:0] vn [3] = '{8'd255, 8'd15, 8'd0};
    logic [3:0] vd [3] = '{4'd1, 4'd15, 4'd5};
    logic [7:0] eq [3] = '{8'd255, 8'd1, 8'd0};
    logic [3:0] er [3] = '{4'd0, 4'd0, 4'd0};
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    for (int i = 0; i < 3; i++) begin
      run_op(vn[i], vd[i], 1, lat, q, r, z);
      checks++; if (q !== eq[i]) $display("FAIL corner_quotient n=%0d d=%0d got=%0d exp=%0d", vn[i], vd[i], q, eq[i]); else passes++;
      checks++; if (r !== er[i]) $display("FAIL corner_remainder n=%0d d=%0d got=%0d exp=%0d", vn[i], vd[i], r, er[i]); else passes++;
      checks++; if (lat !== 9) $display("FAIL corner_latency n=%0d d=%0d got=%0d exp=9", vn[i], vd[i], lat); else passes++;
    end
  endtask

  task automatic test_div_zero;
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    run_op(8'd9, 4'd0, 0, lat, q, r, z);
    checks++; if (lat !== 1) $display("FAIL dbz_latency got=%0d exp=1", lat); else passes++;
    checks++; if (q !== 8'hFF) $display("FAIL dbz_quotient got=%0h exp=ff", q); else passes++;
    checks++; if (r !== 4'd0) $display("FAIL dbz_remainder got=%0d exp=0", r); else passes++;
    checks++; if (z !== 1'b1) $display("FAIL dbz_flag got=%b exp=1", z); else passes++;
  endtask

  task automatic test_backpressure;
    int lat;
    in_valid = 1'b1; dividend = 8'd50; divisor = 4'd6;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin tick; lat++; end
    checks++; if (lat !== 9) $display("FAIL bp_latency got=%0d exp=9", lat); else passes++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 8'(i * 37 + 3);
      divisor  = 4'(i + 1);
      tick;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); else passes++;
      checks++; if (quotient !== 8'd8) $display("FAIL bp_quotient cyc=%0d got=%0d exp=8", i, quotient); else passes++;
      checks++; if (remainder !== 4'd2) $display("FAIL bp_remainder cyc=%0d got=%0d exp=2", i, remainder); else passes++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else passes++;
    tick;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_ghost_result got=%b exp=0", out_valid); else passes++;
  endtask

  task automatic test_reset_abort;
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    in_valid = 1'b1; dividend = 8'd100; divisor = 4'd3;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    checks++; if (in_ready !== 1'b0) $display("FAIL abort_busy got=%b exp=0", in_ready); else passes++;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b exp=1", in_ready); else passes++;
    checks++; if (quotient !== 8'd0) $display("FAIL abort_quotient got=%0d exp=0", quotient); else passes++;
    run_op(8'd100, 4'd3, 0, lat, q, r, z);
    checks++; if (q !== 8'd33) $display("FAIL abort_redo_quotient got=%0d exp=33", q); else passes++;
    checks++; if (r !== 4'd1) $display("FAIL abort_redo_remainder got=%0d exp=1", r); else passes++;
    checks++; if (lat !== 9) $display("FAIL abort_redo_latency got=%0d exp=9", lat); else passes++;
  endtask

  task automatic test_back_to_back;
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    run_op(8'd77, 4'd10, 0, lat, q, r, z);
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_handshake got=%b exp=1", in_ready); else passes++;
    run_op(8'd143, 4'd11, 0, lat, q, r, z);
    checks++; if (q !== 8'd13) $display("FAIL b2b_quotient got=%0d exp=13", q); else passes++;
    checks++; if (r !== 4'd0) $display("FAIL b2b_remainder got=%0d exp=0", r); else passes++;
  endtask

  task automatic test_exhaustive;
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    int stall;
    for (int n = 0; n < 256; n++) begin
      for (int d = 1; d < 16; d++) begin
        stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        run_op(8'(n), 4'(d), stall, lat, q, r, z);
        checks++;
        if (lat != 9 || z !== 1'b0 || (mult_model(int'(q), d) + int'(r)) != n ||
            int'(r) >= d || int'(q) != n / d)
          $display("FAIL exhaustive n=%0d d=%0d got q=%0d r=%0d dbz=%b lat=%0d exp q=%0d r=%0d lat=9",
                   n, d, q, r, z, lat, n / d, n % d);
        else
          passes++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    test_reset;
    test_basic;
    test_corners;
    test_div_zero;
    test_backpressure;
    test_reset_abort;
    test_back_to_back;
    test_exhaustive;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
